// File: rtl/clkgate_pkg.sv
// ============================================================================
// Module      : clkgate_pkg
// Description : Shared constants and the counter-width helper for the
//               hysteretic clock-gate array.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

package clkgate_pkg;

   localparam int HOLD_MAX = 255;

   // Counter width for values 0..v-1, never narrower than one bit
   function automatic int clog2_min1(input int v);
      int w;
      w = $clog2(v);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

`default_nettype wire

// File: rtl/clkgate_chan.sv
// ============================================================================
// Module      : clkgate_chan
// Description : One gated-clock channel: idle-hold counter, low-phase
//               enable latch and output AND. Optional TE input is present
//               when CLKGATE_TEST_OVERRIDE_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module clkgate_chan
   import clkgate_pkg::*;
#(
   parameter int HOLD = 3
) (
   input  logic CK,
   input  logic RN,
`ifdef CLKGATE_TEST_OVERRIDE_EN
   input  logic TE,
`endif
   input  logic E,
   output logic GCK,
   output logic IQ
);

   localparam int CW = clog2_min1(HOLD + 1);

   logic [CW-1:0] r_cnt;
   logic          w_busy;
   logic          w_en_req;
   logic          r_iq;

   generate
      if (HOLD == 0) begin : g_plain
         assign r_cnt = '0;
      end else begin : g_hyst
         localparam logic [CW-1:0] c_hold = CW'(HOLD);
         always_ff @(posedge CK or negedge RN) begin
            if (!RN) begin
               r_cnt <= '0;
            end else if (E) begin
               r_cnt <= c_hold;
            end else if (r_cnt != '0) begin
               r_cnt <= r_cnt - CW'(1);
            end
         end
      end
   endgenerate

   assign w_busy = (r_cnt != '0);

`ifdef CLKGATE_TEST_OVERRIDE_EN
   assign w_en_req = E | w_busy | TE;
`else
   assign w_en_req = E | w_busy;
`endif

   // Transparent only while CK is low, so the AND below cannot emit runts;
   // reset clears it at once, truncating any pulse in flight.
   always_latch begin
      if (!RN) begin
         r_iq <= 1'b0;
      end else if (!CK) begin
         r_iq <= w_en_req;
      end
   end

   assign GCK = CK & r_iq;
   assign IQ  = r_iq;

endmodule

`default_nettype wire

// File: rtl/clkgate_array_hyst.sv
// ============================================================================
// Module      : clkgate_array_hyst
// Description : N_CH independent glitch-free clock gates with HOLD-cycle idle
//               hysteresis. CLKGATE_TEST_OVERRIDE_EN adds a TE scan override.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module clkgate_array_hyst
   import clkgate_pkg::*;
#(
   parameter int N_CH = 4,
   parameter int HOLD = 3
) (
   input  logic            CK,
   input  logic            RN,
`ifdef CLKGATE_TEST_OVERRIDE_EN
   input  logic            TE,
`endif
   input  logic [N_CH-1:0] E,
   output logic [N_CH-1:0] GCK,
   output logic [N_CH-1:0] ACTIVE,
   output logic            ALL_IDLE
);

   generate
      if (HOLD > HOLD_MAX || HOLD < 0) begin : g_hold_range_err
         $error("clkgate_array_hyst: HOLD out of range");
      end
      if (N_CH < 1) begin : g_nch_range_err
         $error("clkgate_array_hyst: N_CH must be at least 1");
      end

      for (genvar i = 0; i < N_CH; i++) begin : g_ch
         clkgate_chan #(
            .HOLD (HOLD)
         ) u_chan (
            .CK  (CK),
            .RN  (RN),
`ifdef CLKGATE_TEST_OVERRIDE_EN
            .TE  (TE),
`endif
            .E   (E[i]),
            .GCK (GCK[i]),
            .IQ  (ACTIVE[i])
         );
      end
   endgenerate

   assign ALL_IDLE = ~|ACTIVE;

endmodule

`default_nettype wire

// File: tb/tb_clkgate_array_hyst.sv
// ============================================================================
// Module      : tb_clkgate_array_hyst
// Description : Directed self-checking bench for the clock-gate array, with a
//               HOLD=3 instance and a HOLD=0 instance sharing CK/RN/E.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_clkgate_array_hyst;

   logic       CK;
   logic       RN;
   logic       TE;
   logic [3:0] E;
   logic [3:0] GCK, ACTIVE;
   logic       ALL_IDLE;
   logic [3:0] GCK0, ACTIVE0;
   logic       ALL_IDLE0;

   int n_chk;
   int n_err;
   int n_glitch;
   time t_ck_rise;

   clkgate_array_hyst #(.N_CH(4), .HOLD(3)) dut (
      .CK       (CK),
      .RN       (RN),
`ifdef CLKGATE_TEST_OVERRIDE_EN
      .TE       (TE),
`endif
      .E        (E),
      .GCK      (GCK),
      .ACTIVE   (ACTIVE),
      .ALL_IDLE (ALL_IDLE)
   );

   clkgate_array_hyst #(.N_CH(4), .HOLD(0)) dut0 (
      .CK       (CK),
      .RN       (RN),
`ifdef CLKGATE_TEST_OVERRIDE_EN
      .TE       (TE),
`endif
      .E        (E),
      .GCK      (GCK0),
      .ACTIVE   (ACTIVE0),
      .ALL_IDLE (ALL_IDLE0)
   );

   initial CK = 1'b0;
   always #5 CK = ~CK;

   always @(posedge CK) t_ck_rise = $time;

   // Any gated-clock rise must coincide with a source-clock rise
   for (genvar i = 0; i < 4; i++) begin : g_glitch
      always @(posedge GCK[i])  if ($time != t_ck_rise || !CK) n_glitch++;
      always @(posedge GCK0[i]) if ($time != t_ck_rise || !CK) n_glitch++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Apply E in the high phase, then sample 2 ns after the next rising edge
   task automatic cyc(input logic [3:0] e);
      E = e;
      @(posedge CK);
      #2;
   endtask

   task automatic cyc_chk(input string tag, input logic [3:0] e, input logic [3:0] exp_gck);
      cyc(e);
      check(tag, {28'd0, GCK}, {28'd0, exp_gck});
   endtask

   initial begin
      n_chk = 0; n_err = 0; n_glitch = 0; t_ck_rise = 0;
      TE = 1'b0;
      RN = 1'b0;
      E  = 4'hF;

      // Reset held with all enables requested
      repeat (3) begin
         @(posedge CK); #2;
         check("rst_gck", {28'd0, GCK}, 32'h0);
      end
      check("rst_active",   {28'd0, ACTIVE}, 32'h0);
      check("rst_all_idle", {31'd0, ALL_IDLE}, 32'h1);
      check("rst_gck0",     {28'd0, GCK0}, 32'h0);

      RN = 1'b1;
      cyc_chk("first_pulse", 4'hF, 4'hF);
      check("first_active", {28'd0, ACTIVE}, 32'hF);
      check("first_idle",   {31'd0, ALL_IDLE}, 32'h0);
      cyc_chk("hold_all1", 4'h0, 4'hF);
      cyc_chk("hold_all2", 4'h0, 4'hF);
      cyc_chk("hold_all3", 4'h0, 4'hF);
      cyc_chk("hold_all_end", 4'h0, 4'h0);
      check("idle_active", {28'd0, ACTIVE}, 32'h0);
      check("idle_all",    {31'd0, ALL_IDLE}, 32'h1);

      // Single-cycle request on channel 0: 1 + HOLD pulses
      cyc_chk("hyst_k",   4'h1, 4'h1);
      cyc_chk("hyst_k1",  4'h0, 4'h1);
      cyc_chk("hyst_k2",  4'h0, 4'h1);
      cyc_chk("hyst_k3",  4'h0, 4'h1);
      check("hyst_active_k3", {28'd0, ACTIVE}, 32'h1);
      cyc_chk("hyst_k4",  4'h0, 4'h0);
      check("hyst_active_k4", {28'd0, ACTIVE}, 32'h0);

      // Retrigger on channel 1 while its counter is still running
      cyc_chk("retrig_20", 4'h2, 4'h2);
      cyc_chk("retrig_21", 4'h0, 4'h2);
      cyc_chk("retrig_22", 4'h0, 4'h2);
      cyc_chk("retrig_23", 4'h2, 4'h2);
      cyc_chk("retrig_24", 4'h0, 4'h2);
      cyc_chk("retrig_25", 4'h0, 4'h2);
      cyc_chk("retrig_26", 4'h0, 4'h2);
      cyc_chk("retrig_27", 4'h0, 4'h0);

      // Overlapping independent bursts
      cyc_chk("indep_a",  4'b1001, 4'h9);
      cyc_chk("indep_a1", 4'b0100, 4'hD);
      cyc_chk("indep_a2", 4'b0000, 4'hD);
      cyc_chk("indep_a3", 4'b0000, 4'hD);
      cyc_chk("indep_a4", 4'b0000, 4'h4);
      cyc_chk("indep_a5", 4'b0000, 4'h0);

      // HOLD=0 instance behaves as a plain single-cycle ICG
      for (int k = 0; k < 6; k++) begin
         logic [3:0] ev;
         ev = (k % 2 == 0) ? 4'h4 : 4'h0;
         cyc(ev);
         check("plain_gck0", {28'd0, GCK0}, {28'd0, ev});
      end
      cyc(4'h0);
      check("plain_gck0_end", {28'd0, GCK0}, 32'h0);
      check("plain_idle0",    {31'd0, ALL_IDLE0}, 32'h1);
      repeat (4) cyc(4'h0);

      // Enable edges landing inside the high phase must not change GCK
      E = 4'hA;
      #1;
      check("highphase_gck", {28'd0, GCK}, 32'h0);
      @(negedge CK); #1;
      check("highphase_active", {28'd0, ACTIVE}, 32'hA);
      cyc_chk("highphase_pulse", 4'hA, 4'hA);

`ifdef CLKGATE_TEST_OVERRIDE_EN
      repeat (5) cyc(4'h0);
      TE = 1'b1;
      cyc_chk("te_on1", 4'h0, 4'hF);
      check("te_on_gck0", {28'd0, GCK0}, 32'hF);
      cyc_chk("te_on2", 4'h0, 4'hF);
      TE = 1'b0;
      cyc_chk("te_off", 4'h0, 4'h0);
      check("te_off_gck0", {28'd0, GCK0}, 32'h0);
`endif

      // Reset in the middle of a high phase cuts the pulse immediately
      cyc_chk("mid_pre", 4'hF, 4'hF);
      RN = 1'b0;
      #1;
      check("mid_ck_high", {31'd0, CK}, 32'h1);
      check("mid_gck",     {28'd0, GCK}, 32'h0);
      check("mid_idle",    {31'd0, ALL_IDLE}, 32'h1);
      cyc(4'hF);
      check("mid_held", {28'd0, GCK}, 32'h0);
      RN = 1'b1;
      cyc_chk("mid_release", 4'h0, 4'h0);

      check("glitch_count", n_glitch, 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

`default_nettype wire
